// File: rtl/ttrng_multi.sv
// Multi-channel Galois-LFSR random number generator with raw/dice/coin/range draw
// modes, rejection sampling bounded by a retry limit, and runtime per-channel seeding.

module ttrng_lane #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] POLY     = 16'hB400,
  parameter logic [WIDTH-1:0] RST_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);
  // An all-zero state would lock the LFSR, so zero seeds become 1.
  localparam logic [WIDTH-1:0] RST_VAL = (RST_SEED == '0) ? WIDTH'(1) : RST_SEED;

  always_ff @(posedge clk) begin
    if (rst)
      state <= RST_VAL;
    else if (load)
      state <= (load_val == '0) ? WIDTH'(1) : load_val;
    else if (step)
      state <= (state >> 1) ^ (state[0] ? POLY : '0);
  end
endmodule

module ttrng_multi #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] POLY         = 16'hB400,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
  parameter int               CHANNELS     = 4,
  parameter int               OUT_W        = 8,
  parameter int               MAX_COUNT    = 1000,
  localparam int              CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [CW-1:0]    seed_ch,
  input  logic [WIDTH-1:0] seed,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CW-1:0]    req_ch,
  input  logic [1:0]       req_mode,
  input  logic [OUT_W-1:0] req_bound,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] number,
  output logic [CW-1:0]    out_ch,
  output logic             timeout
);
  localparam int              AW   = $clog2(MAX_COUNT + 1);
  localparam logic [AW-1:0]   LAST = AW'(MAX_COUNT - 1);
  localparam logic [CW:0]     NCH  = (CW + 1)'(CHANNELS);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  typedef struct packed {
    logic [CW-1:0]    ch;
    logic [1:0]       mode;
    logic [OUT_W-1:0] bound;
  } req_t;

  state_t state, state_n;
  req_t   cur, cur_n;
  logic [AW-1:0]    attempts, attempts_n;
  logic [OUT_W-1:0] number_n;
  logic [CW-1:0]    out_ch_n;
  logic             timeout_n, out_valid_n;

  logic [CHANNELS-1:0][WIDTH-1:0] lane_state;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    ttrng_lane #(
      .WIDTH   (WIDTH),
      .POLY    (POLY),
      .RST_SEED(DEFAULT_SEED + WIDTH'(c))
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (seed_load && (seed_ch == CW'(c))),
      .load_val(seed),
      .step    ((state == DRAW) && (cur.ch == CW'(c))),
      .state   (lane_state[c])
    );
  end

  // Candidate comes from the pre-step state of the latched channel.
  logic [WIDTH-1:0] sel;
  logic [OUT_W-1:0] cand, b1, mask, masked, res;
  logic             accept;

  always_comb begin
    sel = '0;
    if ({1'b0, cur.ch} < NCH) sel = lane_state[cur.ch];
    cand = sel[OUT_W-1:0];
  end

  always_comb begin
    accept = 1'b0;
    res    = '0;
    b1     = cur.bound - OUT_W'(1);
    mask   = '0;
    masked = '0;
    unique case (cur.mode)
      2'd0: begin
        accept = 1'b1;
        res    = cand;
      end
      2'd1: begin
        accept = (cand[2:0] <= 3'd5);
        res    = OUT_W'(cand[2:0]) + OUT_W'(1);
      end
      2'd2: begin
        accept = 1'b1;
        res    = {{(OUT_W-1){1'b0}}, cand[0]};
      end
      default: begin
        if (cur.bound <= OUT_W'(1)) begin
          accept = 1'b1;
        end else begin
          // Smear bound-1 rightwards: smallest all-ones mask covering it.
          for (int i = 0; i < OUT_W; i++) mask[i] = |(b1 >> i);
          masked = cand & mask;
          accept = (masked < cur.bound);
          res    = masked;
        end
      end
    endcase
  end

  always_comb begin
    state_n     = state;
    cur_n       = cur;
    attempts_n  = attempts;
    number_n    = number;
    out_ch_n    = out_ch;
    timeout_n   = timeout;
    out_valid_n = out_valid;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          cur_n      = '{ch: req_ch, mode: req_mode, bound: req_bound};
          attempts_n = '0;
          state_n    = DRAW;
        end
      end
      DRAW: begin
        if (accept) begin
          number_n    = res;
          out_ch_n    = cur.ch;
          timeout_n   = 1'b0;
          out_valid_n = 1'b1;
          state_n     = DONE;
        end else if (attempts == LAST) begin
          number_n    = '0;
          out_ch_n    = cur.ch;
          timeout_n   = 1'b1;
          out_valid_n = 1'b1;
          state_n     = DONE;
        end else begin
          attempts_n = attempts + AW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      attempts  <= '0;
      number    <= '0;
      out_ch    <= '0;
      timeout   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      attempts  <= attempts_n;
      number    <= number_n;
      out_ch    <= out_ch_n;
      timeout   <= timeout_n;
      out_valid <= out_valid_n;
    end
  end

  assign req_ready = (state == IDLE);
endmodule

// File: tb/tb_ttrng_multi.sv
// Directed plus randomized bench for ttrng_multi against a behavioural draw model.
module tb_ttrng_multi;
  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load, req_valid, out_ready;
  logic [1:0]  seed_ch, req_ch, req_mode, out_ch;
  logic [15:0] seed;
  logic [7:0]  req_bound, number;
  logic        req_ready, out_valid, timeout;

  // second instance with a single allowed rejection
  logic        s_seed_load, s_req_valid, s_out_ready;
  logic [1:0]  s_seed_ch, s_req_ch, s_req_mode, s_out_ch;
  logic [15:0] s_seed;
  logic [7:0]  s_req_bound, s_number;
  logic        s_req_ready, s_out_valid, s_timeout;

  int total = 0;
  int bad   = 0;
  int last_num;
  int cyc;

  logic [15:0] ms [4];

  always #5 clk = ~clk;

  ttrng_multi dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_ch(seed_ch), .seed(seed),
    .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_mode(req_mode),
    .req_bound(req_bound), .out_valid(out_valid), .out_ready(out_ready),
    .number(number), .out_ch(out_ch), .timeout(timeout)
  );

  ttrng_multi #(.MAX_COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .seed_load(s_seed_load), .seed_ch(s_seed_ch), .seed(s_seed),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_ch(s_req_ch), .req_mode(s_req_mode),
    .req_bound(s_req_bound), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .number(s_number), .out_ch(s_out_ch), .timeout(s_timeout)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) ms[c] = 16'hACE1 + 16'(c);
  endtask

  // One draw on the model: returns result, timeout flag and number of draw cycles.
  task automatic ref_draw(input int ch, input int mode, input int bound, input int maxc,
                          output int num, output int to, output int steps);
    int  c, v, att;
    bit  acc, fin;
    att = 0; steps = 0; fin = 0; num = 0; to = 0;
    while (!fin) begin
      c = int'(ms[ch] & 16'h00FF);
      ms[ch] = lfsr_next(ms[ch]);
      steps++;
      case (mode)
        0: begin acc = 1; v = c; end
        1: begin acc = (c % 8) <= 5; v = (c % 8) + 1; end
        2: begin acc = 1; v = c % 2; end
        default: begin
          if (bound <= 1) begin acc = 1; v = 0; end
          else begin
            int m = 0;
            while (m < bound - 1) m = m * 2 + 1;
            v = c & m;
            acc = v < bound;
          end
        end
      endcase
      if (acc) begin num = v; to = 0; fin = 1; end
      else if (att + 1 == maxc) begin num = 0; to = 1; fin = 1; end
      else att++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_seed(input int ch, input logic [15:0] val);
    seed_load = 1'b1; seed_ch = 2'(ch); seed = val;
    @(posedge clk); #1;
    seed_load = 1'b0;
    ms[ch] = (val == 16'h0) ? 16'h1 : val;
  endtask

  // Issue one request, wait for the result, compare against the model, then consume.
  task automatic run_draw(input string tag, input int ch, input int mode, input int bound);
    int en, et, es;
    ref_draw(ch, mode, bound, 1000, en, et, es);
    req_ch = 2'(ch); req_mode = 2'(mode); req_bound = 8'(bound); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    check({tag, ".valid"}, int'(out_valid), 1);
    check({tag, ".num"}, int'(number), en);
    check({tag, ".to"}, int'(timeout), et);
    check({tag, ".ch"}, int'(out_ch), ch);
    check({tag, ".lat"}, cyc, es);
    last_num = int'(number);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".idle"}, int'(req_ready), 1);
  endtask

  initial begin
    rst = 1'b1; seed_load = 0; seed_ch = 0; seed = 0; req_valid = 0; req_ch = 0;
    req_mode = 0; req_bound = 0; out_ready = 0;
    s_seed_load = 0; s_seed_ch = 0; s_seed = 0; s_req_valid = 0; s_req_ch = 0;
    s_req_mode = 0; s_req_bound = 0; s_out_ready = 0;
    @(posedge clk); #1;
    do_reset();

    check("rst.ready", int'(req_ready), 1);
    check("rst.valid", int'(out_valid), 0);
    check("rst.num", int'(number), 0);
    check("rst.ch", int'(out_ch), 0);
    check("rst.to", int'(timeout), 0);

    run_draw("raw1", 0, 0, 0);   check("raw1.const", last_num, 'hE1);
    run_draw("raw2", 0, 0, 0);   check("raw2.const", last_num, 'h70);

    do_reset(); run_draw("dice", 0, 1, 0);   check("dice.const", last_num, 2);
    do_reset(); run_draw("coin", 0, 2, 0);   check("coin.const", last_num, 1);
    do_reset(); run_draw("range", 0, 3, 10); check("range.const", last_num, 1);

    do_reset();
    load_seed(2, 16'h0000);
    run_draw("seed0", 2, 0, 0);  check("seed0.const", last_num, 1);
    run_draw("ch1", 1, 0, 0);    check("ch1.const", last_num, 'hE2);

    // single-rejection limit: seed 7 gives dice candidate 7, rejected once
    s_seed_load = 1; s_seed_ch = 0; s_seed = 16'h0007;
    @(posedge clk); #1;
    s_seed_load = 0; s_req_ch = 0; s_req_mode = 1; s_req_valid = 1;
    @(posedge clk); #1;
    s_req_valid = 0;
    cyc = 0;
    while (!s_out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("tmo.valid", int'(s_out_valid), 1);
    check("tmo.num", int'(s_number), 0);
    check("tmo.to", int'(s_timeout), 1);
    check("tmo.ch", int'(s_out_ch), 0);
    s_out_ready = 1;
    @(posedge clk); #1;
    s_out_ready = 0;

    // backpressure: result must hold; a stray request must not start a draw
    begin
      int en, et, es, held;
      ref_draw(3, 0, 0, 1000, en, et, es);
      req_ch = 3; req_mode = 0; req_valid = 1;
      @(posedge clk); #1;
      req_valid = 0;
      cyc = 0;
      while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
      check("bp.num0", int'(number), en);
      held = int'(number);
      for (int k = 0; k < 5; k++) begin
        req_valid = (k == 2); req_ch = 1;
        @(posedge clk); #1;
        check("bp.valid", int'(out_valid), 1);
        check("bp.num", int'(number), held);
        check("bp.ready", int'(req_ready), 0);
      end
      req_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      check("bp.idle", int'(req_ready), 1);
      check("bp.vclr", int'(out_valid), 0);
      run_draw("bp.ch1", 1, 0, 0);
    end

    // reset while drawing abandons the draw and restores seeds
    req_ch = 0; req_mode = 1; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check("mrst.valid", int'(out_valid), 0);
    check("mrst.ready", int'(req_ready), 1);
    run_draw("mrst.raw", 0, 0, 0); check("mrst.const", last_num, 'hE1);

    // randomized draws with occasional seed loads
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        load_seed(int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom));
      run_draw("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2))
                                           : int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
